// File: rtl/m_burst_drain_if.sv
// Bundles the FIFO read side and the output stream of the burst drain.
// Latency: none; wires only.
// Backpressure: out_ready from the sink, fifo_pop back to the FIFO.
interface m_burst_drain_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 9
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] fifo_data;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             fifo_pop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    // master: the burst drain itself
    modport master (
        input  fifo_data, fifo_empty, fifo_count, out_ready,
        output fifo_pop, out_valid, out_data, out_last
    );

    // slave: the FIFO plus the burst sink surrounding the drain
    modport slave (
        output fifo_data, fifo_empty, fifo_count, out_ready,
        input  fifo_pop, out_valid, out_data, out_last
    );
endinterface

// File: rtl/m_burst_drain.sv
// Waits for BURST_LEN queued FIFO words, then pops them back-to-back onto a registered stream, tagging the final beat with out_last.
// Latency: 1 cycle from threshold to first pop; pop in cycle N shows on out_data in cycle N+1; 1 word/cycle with out_ready high.
// Backpressure: a stalled output register (out_valid & ~out_ready) blocks popping; M_BURST_DRAIN_TIMEOUT_EN adds partial-burst flush.
module m_burst_drain #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 9,
    parameter int               BURST_LEN = 4,
    parameter int               TIMEOUT   = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    m_burst_drain_if.master  bus,
    output logic             busy
);
    localparam int            CW          = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
    localparam logic [CW-1:0] ONE         = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] len;
    logic [CW-1:0] len_nxt;
    logic          pop_ok;
    logic          pop;
    logic          last_pop;
    logic          start;
    logic          timed_out;

`ifdef M_BURST_DRAIN_TIMEOUT_EN
    localparam int            WW           = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TIMEOUT_LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] wait_cnt;
    logic          partial;

    // a non-empty FIFO that is still short of a full burst
    assign partial   = (bus.fifo_count != '0) && (bus.fifo_count < BURST_LEN_C);
    assign timed_out = (state == IDLE) && partial && (wait_cnt == TIMEOUT_LAST);

    // count idle cycles spent holding a partial burst; any FSM movement restarts the wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state != IDLE) || (state_nxt != IDLE) || !partial) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end
`else
    // without the flush option a partial FIFO is simply held
    assign timed_out = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state, burst length selection and the pop strobe
    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        start     = 1'b0;
        pop       = 1'b0;
        last_pop  = 1'b0;
        pop_ok    = ~bus.out_valid | bus.out_ready;
        case (state)
            IDLE: begin
                if (bus.fifo_count >= BURST_LEN_C) begin
                    start     = 1'b1;
                    state_nxt = BURST;
                    len_nxt   = BURST_LEN_C;
                end else if (timed_out) begin
                    start     = 1'b1;
                    state_nxt = BURST;
                    len_nxt   = bus.fifo_count;
                end
            end
            BURST: begin
                pop      = ~bus.fifo_empty & pop_ok;
                last_pop = pop & (beat_cnt == len - ONE);
                if (last_pop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.fifo_pop = pop;
    assign busy         = (state == BURST);

    // burst length and beat position within the current burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len      <= '0;
            beat_cnt <= '0;
        end else begin
            len <= len_nxt;
            if (start) begin
                beat_cnt <= '0;
            end else if (pop) begin
                beat_cnt <= last_pop ? '0 : beat_cnt + ONE;
            end
        end
    end

    // output register: load on pop, empty when drained without a refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= RESET_VAL;
        end else if (pop) begin
            bus.out_valid <= 1'b1;
            bus.out_last  <= last_pop;
            bus.out_data  <= bus.fifo_data;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end
    end

    m_assert_params: assert property (@(posedge clk)
        (BURST_LEN >= 1) && (BURST_LEN <= DEPTH) && (TIMEOUT >= 1))
        else $error("BAD PARAMETERS!");

    m_assert_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        bus.fifo_pop |-> !bus.fifo_empty)
        else $error("POP ON EMPTY!");

    m_assert_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_data) && $stable(bus.out_last)))
        else $error("OUT_DATA CHANGED WHILE STALLED!");
endmodule

// File: tb/tb_m_burst_drain.sv
// Directed bench for m_burst_drain: a queue-based FIFO feeds the drain, a scoreboard of expected beats checks the stream.
// Latency: cycle indices in the tables count from the cycle the FIFO first holds the burst-completing word.
// Backpressure: out_ready is driven per cycle from a ready-from index in each capture.
module tb_m_burst_drain;
    localparam int               WIDTH     = 8;
    localparam int               DEPTH     = 9;
    localparam int               BURST_LEN = 4;
    localparam int               TIMEOUT   = 16;
    localparam int               CW        = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;
`ifdef M_BURST_DRAIN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    logic rdy   = 1'b0;

    m_burst_drain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    m_burst_drain #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN),
        .TIMEOUT(TIMEOUT), .RESET_VAL(RESET_VAL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: registered count/empty, head word presented combinationally
    logic             push     = 1'b0;
    logic             fifo_clr = 1'b0;
    logic [WIDTH-1:0] push_dat = '0;
    logic [WIDTH-1:0] fq[$];
    int               f_cnt    = 0;
    logic [WIDTH-1:0] f_head   = '0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            fq.delete();
        end else begin
            if (bus.fifo_pop && fq.size() != 0) void'(fq.pop_front());
            if (push && fq.size() < DEPTH) fq.push_back(push_dat);
        end
        f_cnt  <= fq.size();
        f_head <= (fq.size() != 0) ? fq[0] : '0;
    end

    assign bus.fifo_data  = f_head;
    assign bus.fifo_empty = (f_cnt == 0);
    assign bus.fifo_count = CW'(f_cnt);
    assign bus.out_ready  = rdy;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_dat[$];
    logic             exp_lst[$];
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_dat   = '0;
    logic             prev_lst   = 1'b0;

    logic             cap_pop[128];
    logic             cap_vld[128];
    logic             cap_lst[128];
    logic             cap_bsy[128];
    logic [WIDTH-1:0] cap_dat[128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [WIDTH-1:0] d, input logic l);
        exp_dat.push_back(d);
        exp_lst.push_back(l);
    endtask

    // one clock: sample and check at the falling edge, then move 1 unit past the next rising edge
    task automatic step(input int c);
        @(negedge clk);
        if (c >= 0 && c < 128) begin
            cap_pop[c] = bus.fifo_pop;
            cap_vld[c] = bus.out_valid;
            cap_lst[c] = bus.out_last;
            cap_bsy[c] = busy;
            cap_dat[c] = bus.out_data;
        end
        if (rst_n) begin
            if (bus.fifo_empty) chk("pop_on_empty", 32'(bus.fifo_pop), 0);
            if (stall_prev) begin
                chk("stall_data_stable", 32'(bus.out_data), 32'(prev_dat));
                chk("stall_last_stable", 32'(bus.out_last), 32'(prev_lst));
            end
            if (bus.out_valid && !bus.out_ready) chk("no_pop_while_stalled", 32'(bus.fifo_pop), 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_dat.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", bus.out_data);
                end else begin
                    chk("beat_data", 32'(bus.out_data), 32'(exp_dat[0]));
                    chk("beat_last", 32'(bus.out_last), 32'(exp_lst[0]));
                    void'(exp_dat.pop_front());
                    void'(exp_lst.pop_front());
                end
            end
            stall_prev = bus.out_valid & ~bus.out_ready;
            prev_dat   = bus.out_data;
            prev_lst   = bus.out_last;
        end else begin
            exp_dat.delete();
            exp_lst.delete();
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int n, input int rdy_from);
        for (int c = 0; c < n; c++) begin
            rdy = (c >= rdy_from);
            if (c > 0) push = 1'b0;
            step(c);
        end
    endtask

    task automatic masks(input int n, output logic [31:0] pm, output logic [31:0] vm,
                         output logic [31:0] lm, output logic [31:0] bm);
        pm = '0; vm = '0; lm = '0; bm = '0;
        for (int c = 0; c < n && c < 32; c++) begin
            pm[c] = cap_pop[c];
            vm[c] = cap_vld[c];
            lm[c] = cap_lst[c];
            bm[c] = cap_bsy[c];
        end
    endtask

    task automatic counts(input int n, output int np, output int nv, output int nb);
        np = 0; nv = 0; nb = 0;
        for (int c = 0; c < n; c++) begin
            np += int'(cap_pop[c]);
            nv += int'(cap_vld[c]);
            nb += int'(cap_bsy[c]);
        end
    endtask

    // reset DUT and FIFO, preload n words base, base+1, ... while the DUT is held in reset
    task automatic do_reset(input int n, input logic [WIDTH-1:0] base);
        rst_n    = 1'b0;
        push     = 1'b0;
        fifo_clr = 1'b1;
        step(-1);
        fifo_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            push     = 1'b1;
            push_dat = base + WIDTH'(i);
            step(-1);
        end
        push  = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pm, vm, lm, bm;
        int          np, nv, nb;

        // reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_out_data", 32'(bus.out_data), 32'(RESET_VAL));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fifo_pop", 32'(bus.fifo_pop), 0);

        if (!TO_EN) begin
            // partial FIFO is held: 3 words, 100 cycles, nothing happens
            do_reset(3, 8'h20);
            capture(100, 0);
            counts(100, np, nv, nb);
            chk("hold3_pops", 32'(np), 0);
            chk("hold3_busy_cycles", 32'(nb), 0);
            chk("hold3_valid_cycles", 32'(nv), 0);
            chk("hold3_fifo_left", 32'(f_cnt), 3);
        end else begin
            // 2 words flushed after 16 idle cycles as a 2-beat short burst
            do_reset(2, 8'h60);
            expect_beat(8'h60, 1'b0);
            expect_beat(8'h61, 1'b1);
            capture(24, 0);
            masks(24, pm, vm, lm, bm);
            chk("to_pop_mask", pm, 32'h0003_0000);
            chk("to_valid_mask", vm, 32'h0006_0000);
            chk("to_last_mask", lm, 32'h0004_0000);
            chk("to_busy_mask", bm, 32'h0003_0000);
            chk("to_fifo_left", 32'(f_cnt), 0);
            chk("to_outstanding", 32'(exp_dat.size()), 0);
        end

        // latency: D pushed in cycle 0 -> pops 2..5, data 3..6, last with D
        rdy = 1'b1;
        do_reset(0, 8'h00);
        expect_beat(8'hA0, 1'b0);
        expect_beat(8'hA1, 1'b0);
        expect_beat(8'hA2, 1'b0);
        expect_beat(8'hA3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push     = 1'b1;
            push_dat = 8'hA0 + WIDTH'(i);
            step(-1);
        end
        push_dat = 8'hA3;
        capture(10, 0);
        masks(10, pm, vm, lm, bm);
        chk("lat_pop_mask", pm, 32'h0000_003C);
        chk("lat_valid_mask", vm, 32'h0000_0078);
        chk("lat_last_mask", lm, 32'h0000_0040);
        chk("lat_busy_mask", bm, 32'h0000_003C);
        chk("lat_data_c3", 32'(cap_dat[3]), 32'h0000_00A0);
        chk("lat_data_c6", 32'(cap_dat[6]), 32'h0000_00A3);
        chk("lat_outstanding", 32'(exp_dat.size()), 0);

        // stall: ready low until cycle 7, A held, then B,C,D back-to-back
        rdy = 1'b0;
        do_reset(4, 8'h40);
        expect_beat(8'h40, 1'b0);
        expect_beat(8'h41, 1'b0);
        expect_beat(8'h42, 1'b0);
        expect_beat(8'h43, 1'b1);
        capture(14, 7);
        masks(14, pm, vm, lm, bm);
        chk("stall_pop_mask", pm, 32'h0000_0382);
        chk("stall_valid_mask", vm, 32'h0000_07FC);
        chk("stall_last_mask", lm, 32'h0000_0400);
        chk("stall_busy_mask", bm, 32'h0000_03FE);
        chk("stall_data_c6", 32'(cap_dat[6]), 32'h0000_0040);
        chk("stall_data_c8", 32'(cap_dat[8]), 32'h0000_0041);
        chk("stall_data_c9", 32'(cap_dat[9]), 32'h0000_0042);
        chk("stall_data_c10", 32'(cap_dat[10]), 32'h0000_0043);
        chk("stall_outstanding", 32'(exp_dat.size()), 0);

        // full FIFO of 9: two bursts of 4, one word left (flushed later with the timeout build)
        do_reset(9, 8'h30);
        for (int i = 0; i < 8; i++) expect_beat(8'h30 + WIDTH'(i), (i % 4) == 3);
        if (TO_EN) expect_beat(8'h38, 1'b1);
        capture(40, 0);
        masks(40, pm, vm, lm, bm);
        counts(40, np, nv, nb);
        chk("full_pop_mask", pm, TO_EN ? 32'h0400_03DE : 32'h0000_03DE);
        chk("full_valid_mask", vm, TO_EN ? 32'h0800_07BC : 32'h0000_07BC);
        chk("full_last_mask", lm, TO_EN ? 32'h0800_0420 : 32'h0000_0420);
        chk("full_busy_mask", bm, TO_EN ? 32'h0400_03DE : 32'h0000_03DE);
        chk("full_pop_count", 32'(np), TO_EN ? 9 : 8);
        chk("full_busy_end", 32'(cap_bsy[39]), 0);
        chk("full_fifo_left", 32'(f_cnt), TO_EN ? 0 : 1);
        chk("full_outstanding", 32'(exp_dat.size()), 0);

        // reset during the 2nd beat clears everything at once; burst is not resumed
        do_reset(4, 8'h50);
        expect_beat(8'h50, 1'b0);
        expect_beat(8'h51, 1'b0);
        expect_beat(8'h52, 1'b0);
        expect_beat(8'h53, 1'b1);
        capture(3, 0);
        chk("mid_pre_data", 32'(bus.out_data), 32'h0000_0051);
        chk("mid_pre_valid", 32'(bus.out_valid), 1);
        chk("mid_pre_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(bus.out_valid), 0);
        chk("mid_out_last", 32'(bus.out_last), 0);
        chk("mid_out_data", 32'(bus.out_data), 32'(RESET_VAL));
        chk("mid_busy", 32'(busy), 0);
        chk("mid_fifo_pop", 32'(bus.fifo_pop), 0);
        step(-1);
        chk("mid_fifo_left", 32'(f_cnt), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
